// File: rtl/tdm_demux4.sv
// TDM 4-slot demultiplexer: rebuilds channels a..d from one slot-serial bus; complete frames appear one cycle after slot 3.
// No backpressure: words arrive whenever din_valid is high; partial, misaligned or stalled frames are dropped and flagged.
module tdm_demux4 #(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             s0,
  output logic             s1,
  output logic             sync_err,
  output logic             timeout_err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_slot, w_slot_nxt;
  logic [15:0]      r_idle_cnt, w_idle_nxt;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
  logic [2:0]       w_sh_we;
  logic             w_load, w_sync, w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_idle_nxt  = r_idle_cnt;
    w_sh_we     = 3'b000;
    w_load      = 1'b0;
    w_sync      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (din_valid) begin
          if (frame_start) begin
            w_sh_we     = 3'b001;
            w_slot_nxt  = 2'd1;
            w_idle_nxt  = '0;
            w_state_nxt = COLLECT;
          end else begin
            w_sync = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (din_valid) begin
          w_idle_nxt = '0;
          if (frame_start) begin
            // Premature restart: drop the partial frame but keep this word as the new slot 0.
            w_sync     = 1'b1;
            w_sh_we    = 3'b001;
            w_slot_nxt = 2'd1;
          end else if (r_slot == 2'd3) begin
            w_load      = 1'b1;
            w_slot_nxt  = 2'd0;
            w_state_nxt = IDLE;
          end else begin
            w_sh_we[r_slot] = 1'b1;
            w_slot_nxt      = r_slot + 2'd1;
          end
        end else if (TIMEOUT != 0 && r_idle_cnt == 16'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_slot_nxt  = 2'd0;
          w_idle_nxt  = '0;
          w_state_nxt = IDLE;
        end else begin
          w_idle_nxt = r_idle_cnt + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slot      <= 2'd0;
      r_idle_cnt  <= '0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_idle_cnt  <= w_idle_nxt;
      frame_valid <= w_load;
      sync_err    <= w_sync;
      timeout_err <= w_tmo;
      if (w_sh_we[0]) r_sh0 <= din;
      if (w_sh_we[1]) r_sh1 <= din;
      if (w_sh_we[2]) r_sh2 <= din;
      // Slot 3 bypasses the shadows so all four channels update on the same edge.
      if (w_load) begin
        a         <= r_sh0;
        b         <= r_sh1;
        c         <= r_sh2;
        d         <= din;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign s0 = r_slot[1];
  assign s1 = r_slot[0];

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed table-driven bench for tdm_demux4 plus hand sequences for timeout, async reset and counter wrap.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [1:0] din;
  logic       din_valid;
  logic       frame_start;
  logic [1:0] a, b, c, d;
  logic       frame_valid, s0, s1, sync_err, timeout_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid), .s0(s0), .s1(s1),
    .sync_err(sync_err), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       fs;
    logic [1:0] din;
    logic [1:0] ea, eb, ec, ed;
    logic       efv;
    logic [1:0] eslot;
    logic       ese;
    logic       ete;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ea, eb, ec, ed,
                         input logic efv, input logic [1:0] eslot, input logic ese,
                         input logic ete, input logic [7:0] ecnt);
    chk({tag, ".abcd"}, {24'd0, a, b, c, d}, {24'd0, ea, eb, ec, ed});
    chk({tag, ".frame_valid"}, {31'd0, frame_valid}, {31'd0, efv});
    chk({tag, ".slot"}, {30'd0, s0, s1}, {30'd0, eslot});
    chk({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, ese});
    chk({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, ete});
    chk({tag, ".frame_cnt"}, {24'd0, frame_cnt}, {24'd0, ecnt});
  endtask

  task automatic drive(input logic v, input logic fs, input logic [1:0] w);
    din_valid   = v;
    frame_start = fs;
    din         = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; din = 2'b00; din_valid = 1'b0; frame_start = 1'b0;
    #3;
    chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0);
    #9 rst_n = 1'b1;

    // v fs din | a b c d | fv slot se te cnt
    // Single frame 01,00,00,00
    vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd2, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1});
    // Back-to-back frames 00,01,00,00 then 00,00,01,11
    vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'd2, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'd2, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'd3, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 1'b1, 2'd0, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3});
    // Premature restart after two words, then full frame of 10s
    vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd1, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd2, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd1, 1'b1, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd2, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0, 2'd3, 1'b0, 1'b0, 8'd3});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 2'd0, 1'b0, 1'b0, 8'd4});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 8'd4});
    // Stray word in IDLE, then frame_start without din_valid is ignored
    vecs.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0, 1'b1, 1'b0, 8'd4});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 8'd4});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0, 1'b0, 1'b0, 8'd4});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].fs, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed,
              vecs[i].efv, vecs[i].eslot, vecs[i].ese, vecs[i].ete, vecs[i].ecnt);
    end

    // Timeout: two words then 16 idle cycles
    drive(1'b1, 1'b1, 2'b01);
    drive(1'b1, 1'b0, 2'b11);
    for (int i = 1; i <= 15; i++) drive(1'b0, 1'b0, 2'b00);
    chk("tmo.before", {31'd0, timeout_err}, 32'd0);
    chk("tmo.slot_mid", {30'd0, s0, s1}, 32'd2);
    drive(1'b0, 1'b0, 2'b00);
    chk_all("tmo.hit", 2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 8'd4);
    drive(1'b0, 1'b0, 2'b00);
    chk("tmo.pulse_end", {31'd0, timeout_err}, 32'd0);
    drive(1'b1, 1'b0, 2'b01);
    chk("tmo.now_idle", {31'd0, sync_err}, 32'd1);

    // Asynchronous reset between edges, mid-frame
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b0, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b1, 2'b01);
    drive(1'b1, 1'b0, 2'b10);
    drive(1'b1, 1'b0, 2'b11);
    drive(1'b1, 1'b0, 2'b01);
    chk_all("post_rst", 2'b01, 2'b10, 2'b11, 2'b01, 1'b1, 2'd0, 1'b0, 1'b0, 8'd1);

    // 255 more back-to-back frames: count reaches 255 then wraps to 0
    for (int f = 2; f <= 256; f++) begin
      drive(1'b1, 1'b1, 2'(f));
      drive(1'b1, 1'b0, 2'(f + 1));
      drive(1'b1, 1'b0, 2'(f + 2));
      drive(1'b1, 1'b0, 2'(f + 3));
      if (f == 255) chk("cnt255", {24'd0, frame_cnt}, 32'd255);
    end
    chk("wrap.cnt", {24'd0, frame_cnt}, 32'd0);
    chk("wrap.fv", {31'd0, frame_valid}, 32'd1);
    chk("wrap.abcd", {24'd0, a, b, c, d}, {24'd0, 8'b00_01_10_11});
    drive(1'b0, 1'b0, 2'b00);
    chk("wrap.fv_end", {31'd0, frame_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4:1 channel multiplexer path.
- Accepts a time-division-multiplexed stream of WIDTH-bit words on one bus, four slots per frame, and rebuilds the four parallel channels a, b, c, d.
- Complete frames are presented on the outputs simultaneously with a one-cycle valid strobe. Partial, misaligned or stalled frames are discarded and flagged.
- Also reports the expected slot as the select pair s0/s1, using the same encoding as the transmit-side multiplexer.

Parameters:
- WIDTH, 2, bits per channel word.
- TIMEOUT, 16, max consecutive cycles without din_valid inside a frame before abort; 0 disables the timeout.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  TDM data word.
- din_valid  input  1  din carries a slot word this cycle.
- frame_start  input  1  qualifies din as slot 0 (channel a); sampled only when din_valid=1.
- a  output  WIDTH  channel 0 (slot {s0,s1}=00).
- b  output  WIDTH  channel 1 (slot 01).
- c  output  WIDTH  channel 2 (slot 10).
- d  output  WIDTH  channel 3 (slot 11).
- frame_valid  output  1  one-cycle pulse: a..d just updated with a complete frame.
- s0  output  1  MSB of the next expected slot index.
- s1  output  1  LSB of the next expected slot index.
- sync_err  output  1  one-cycle pulse: alignment error.
- timeout_err  output  1  one-cycle pulse: frame aborted by timeout.
- frame_cnt  output  8  count of good frames; wraps 255 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): all of the following clear to 0:
  - outputs a, b, c, d, frame_valid, s0, s1, sync_err, timeout_err, frame_cnt;
  - shadow registers, slot counter, idle counter;
  - state goes to IDLE.
- Reset mid-frame discards the partial frame. No error pulse is generated.
- Slot encoding: slot index = {s0,s1}. 0 -> a, 1 -> b, 2 -> c, 3 -> d.
- Slot output: {s0,s1} is the registered slot counter, i.e. the slot the next accepted word fills. It is 00 in IDLE.
- Words land in internal shadow registers only. Outputs a..d never change mid-frame.
- State IDLE:
  - din_valid & frame_start: capture din into shadow slot 0; slot counter = 1; go to COLLECT.
  - din_valid & !frame_start: word dropped; sync_err pulses next cycle; stay in IDLE.
  - !din_valid: hold.
- State COLLECT:
  - din_valid & !frame_start: capture din into shadow[slot]; slot counter increments; idle counter clears.
  - When that accepted word is slot 3:
    - on the next edge, a..d load from the shadows (slot 3 value direct from din) all together;
    - frame_valid = 1 for exactly one cycle;
    - frame_cnt increments (modulo 256);
    - slot counter returns to 0; state returns to IDLE.
  - Latency: frame_valid and new a..d are visible in the cycle after the slot-3 word is sampled.
  - din_valid & frame_start (premature restart): sync_err pulses; partial frame discarded; din captured as the new slot 0; slot counter = 1; stay in COLLECT. The restart is not lost.
  - !din_valid: idle counter increments. When it reaches TIMEOUT (TIMEOUT>0):
    - timeout_err pulses one cycle;
    - partial frame discarded; go to IDLE.
- Back-to-back frames: frame_start with slot 0 of the next frame may arrive in the cycle immediately after slot 3. No gap is required and no error is raised.
- Outputs a..d hold their last good frame indefinitely. Errors and timeouts never alter a..d or frame_cnt.
- Pulse signals (frame_valid, sync_err, timeout_err) are registered and never assert for more than one consecutive cycle per event.
- Each error condition produces one pulse.
- frame_valid and sync_err may coincide only if an error occurs in the same cycle as a completion; this is impossible by construction.

Test Plan:
- Reset then frame 01,00,00,00 with frame_start on word 0, din_valid continuous -> one cycle after word 3: a=01, b=00, c=00, d=00, frame_valid=1 for 1 cycle, frame_cnt=1; {s0,s1} sequence 00,01,10,11,00.
- Two back-to-back frames (00,01,00,00) then (00,00,01,11) -> frame_valid pulses on two cycles 4 apart; final a=00, b=00, c=01, d=11; frame_cnt=2.
- Frame_start reasserted after 2 words, then full frame 10,10,10,10 -> sync_err 1-cycle pulse; no frame_valid for the partial frame; then a=b=c=d=10, frame_cnt=1.
- din_valid without frame_start in IDLE (din=11) -> sync_err pulse; a..d unchanged; {s0,s1} stays 00.
- TIMEOUT=16: two words, then din_valid low 16 cycles -> timeout_err pulse on the 16th idle cycle; state IDLE; a..d retain the previous frame.
- rst_n driven low asynchronously mid-frame (between clock edges) -> all outputs 0 immediately. After release, a full frame 01,10,11,01 -> a=01, b=10, c=11, d=01, frame_cnt=1.
- 256 good frames -> frame_cnt wraps to 0.
